// File: rtl/acc_pkg.sv
// Shared types and default sizes for the decode-stage operand accumulator sequencer.
package acc_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_COLLECT,
    ACC_FULL,
    ACC_BUSY
  } acc_state_t;

  localparam int ACC_DATA_W  = 8;
  localparam int ACC_PC_W    = 12;
  localparam int ACC_DEPTH   = 3;
  localparam int ACC_DONE_TO = 15;

endpackage

// File: rtl/acc_done_timer.sv
// Cycle counter bounding the wait for alu_done while the sequencer is busy.
module acc_done_timer #(
  parameter int DONE_TO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(DONE_TO + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = (cnt_q == CW'(DONE_TO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// Gates decode put/op requests into single-cycle accumulator pulses,
// one per PC, tracking operand fill and holding fetch while the ALU works.
module acc_sequencer
  import acc_pkg::*;
#(
  parameter int DATA_W  = ACC_DATA_W,
  parameter int PC_W    = ACC_PC_W,
  parameter int DEPTH   = ACC_DEPTH,
  parameter int DONE_TO = ACC_DONE_TO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              put_req,
  input  logic              op_req,
  input  logic [1:0]        op_arity,
  input  logic [DATA_W-1:0] value,
  input  logic [PC_W-1:0]   prog_ctr,
  input  logic              alu_done,
  output logic              put_en,
  output logic              op_en,
  output logic [DATA_W-1:0] acc_value,
  output logic [1:0]        fill,
  output logic              stall,
  output logic              err
);

  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  acc_state_t        state_q, state_d;
  logic [1:0]        fill_q, fill_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              put_en_q, put_en_d;
  logic              op_en_q, op_en_d;
  logic [DATA_W-1:0] acc_value_q, acc_value_d;
  logic              err_q, err_d;

  logic       fresh;
  logic       is_both;
  logic       is_put;
  logic       is_op;
  logic [1:0] fill_inc;
  logic       tmr_load;
  logic       tmr_expire;

  assign fresh    = (prog_ctr != last_pc_q) && (put_req || op_req);
  assign is_both  = put_req && op_req;
  assign is_put   = put_req && !op_req;
  assign is_op    = op_req && !put_req;
  assign fill_inc = fill_q + 2'd1;

  acc_done_timer #(
    .DONE_TO (DONE_TO)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .en_i     (state_q == ACC_BUSY),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    last_pc_d   = last_pc_q;
    put_en_d    = 1'b0;
    op_en_d     = 1'b0;
    acc_value_d = acc_value_q;
    err_d       = err_q;
    stall       = 1'b0;
    tmr_load    = 1'b0;

    unique case (state_q)
      ACC_BUSY: begin
        // Stall releases with alu_done; the held request is taken from IDLE.
        stall = fresh && !alu_done;
        if (alu_done) begin
          fill_d  = '0;
          state_d = ACC_IDLE;
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          fill_d  = '0;
          state_d = ACC_IDLE;
        end
      end
      ACC_IDLE, ACC_COLLECT, ACC_FULL: begin
        if (fresh) begin
          unique case (1'b1)
            is_both: begin
              err_d     = 1'b1;
              last_pc_d = prog_ctr;
            end
            is_put: begin
              if (state_q == ACC_FULL) begin
                stall = 1'b1;
              end else begin
                put_en_d    = 1'b1;
                acc_value_d = value;
                fill_d      = fill_inc;
                last_pc_d   = prog_ctr;
                state_d     = (fill_inc == DEPTH_L) ? ACC_FULL
                                                    : ACC_COLLECT;
              end
            end
            is_op: begin
              // Bad arity still fires so the accumulator clears its valids.
              op_en_d   = 1'b1;
              last_pc_d = prog_ctr;
              state_d   = ACC_BUSY;
              tmr_load  = 1'b1;
              if ((op_arity == 2'd0) || (fill_q < op_arity)) begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACC_IDLE;
      fill_q      <= '0;
      last_pc_q   <= '1;
      put_en_q    <= 1'b0;
      op_en_q     <= 1'b0;
      acc_value_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      last_pc_q   <= last_pc_d;
      put_en_q    <= put_en_d;
      op_en_q     <= op_en_d;
      acc_value_q <= acc_value_d;
      err_q       <= err_d;
    end
  end

  assign put_en    = put_en_q;
  assign op_en     = op_en_q;
  assign acc_value = acc_value_q;
  assign fill      = fill_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed vector table, corner-case sequences and randomized traffic
// checked against a behavioural model of acc_sequencer.
module tb_acc_sequencer;

  localparam int DEPTH   = 3;
  localparam int DONE_TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        put_req;
  logic        op_req;
  logic [1:0]  op_arity;
  logic [7:0]  value;
  logic [11:0] prog_ctr;
  logic        alu_done;
  logic        put_en;
  logic        op_en;
  logic [7:0]  acc_value;
  logic [1:0]  fill;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         p;
    bit         o;
    logic [1:0] ar;
    logic [7:0] v;
    logic [11:0] pc;
    bit         d;
    bit         pe;
    bit         oe;
    int         fill;
    bit         st;
    bit         er;
    logic [7:0] acc;
  } vec_t;

  // Behavioural model state
  int          m_fill;
  bit          m_busy;
  int          m_wait;
  logic [11:0] m_last;
  bit          m_err;
  logic [7:0]  m_acc;
  bit          m_pe;
  bit          m_oe;

  always #5 clk = ~clk;

  acc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .put_req   (put_req),
    .op_req    (op_req),
    .op_arity  (op_arity),
    .value     (value),
    .prog_ctr  (prog_ctr),
    .alu_done  (alu_done),
    .put_en    (put_en),
    .op_en     (op_en),
    .acc_value (acc_value),
    .fill      (fill),
    .stall     (stall),
    .err       (err)
  );

  function automatic vec_t V(input int rst, p, o, ar, v, pc, d,
                             input int pe, oe, fl, st, er, acc);
    vec_t r;
    r.rst  = rst[0];
    r.p    = p[0];
    r.o    = o[0];
    r.ar   = ar[1:0];
    r.v    = v[7:0];
    r.pc   = pc[11:0];
    r.d    = d[0];
    r.pe   = pe[0];
    r.oe   = oe[0];
    r.fill = fl;
    r.st   = st[0];
    r.er   = er[0];
    r.acc  = acc[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 0;
    m_busy = 0;
    m_wait = 0;
    m_last = '1;
    m_err  = 0;
    m_acc  = '0;
    m_pe   = 0;
    m_oe   = 0;
  endtask

  task automatic model_eval(input vec_t t, output bit e_stall);
    bit fresh;
    fresh   = (t.pc != m_last) && (t.p || t.o);
    e_stall = 0;
    m_pe    = 0;
    m_oe    = 0;
    if (m_busy) begin
      e_stall = fresh && !t.d;
      if (t.d) begin
        m_busy = 0;
        m_fill = 0;
      end else if (m_wait == DONE_TO - 1) begin
        m_busy = 0;
        m_fill = 0;
        m_err  = 1;
      end else begin
        m_wait++;
      end
    end else if (fresh) begin
      if (t.p && t.o) begin
        m_err  = 1;
        m_last = t.pc;
      end else if (t.p) begin
        if (m_fill == DEPTH) begin
          e_stall = 1;
        end else begin
          m_fill++;
          m_pe   = 1;
          m_acc  = t.v;
          m_last = t.pc;
        end
      end else begin
        m_oe   = 1;
        m_last = t.pc;
        m_busy = 1;
        m_wait = 0;
        if (t.ar == 0 || int'(t.ar) > m_fill) m_err = 1;
      end
    end
    if (t.rst) model_reset();
  endtask

  task automatic step(input vec_t t, input bit directed);
    bit ms;
    reset    = t.rst;
    put_req  = t.p;
    op_req   = t.o;
    op_arity = t.ar;
    value    = t.v;
    prog_ctr = t.pc;
    alu_done = t.d;
    #4;
    model_eval(t, ms);
    chk("stall_model", stall, ms);
    if (directed) chk("stall", stall, t.st);
    @(posedge clk);
    #1;
    chk("put_en_model", put_en, m_pe);
    chk("op_en_model", op_en, m_oe);
    chk("fill_model", fill, m_fill);
    chk("err_model", err, m_err);
    chk("acc_model", acc_value, m_acc);
    if (directed) begin
      chk("put_en", put_en, t.pe);
      chk("op_en", op_en, t.oe);
      chk("fill", fill, t.fill);
      chk("err", err, t.er);
      if (t.pe) chk("acc_value", acc_value, t.acc);
      chk("pulse_excl", put_en & op_en, 0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    model_reset();
    reset = 1'b1; put_req = 0; op_req = 0; op_arity = 0;
    value = 0; prog_ctr = 0; alu_done = 0;
    @(posedge clk);
    #1;

    // rst,put,op,ar,val,pc,done | pe,oe,fill,stall,err,acc
    tbl.push_back(V(1,0,0,0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,5,1,0,    1,0,1,0,0,5));
    tbl.push_back(V(0,1,0,0,6,2,0,    1,0,2,0,0,6));
    tbl.push_back(V(0,1,0,0,7,3,0,    1,0,3,0,0,7));
    tbl.push_back(V(0,0,1,3,0,4,0,    0,1,3,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,    0,0,3,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,1,    0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,9,7,0,    1,0,1,0,0,9));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0,1,0,0,9,7,0,  0,0,1,0,0,0));
    tbl.push_back(V(0,1,0,0,1,8,0,    1,0,2,0,0,1));
    tbl.push_back(V(0,1,0,0,2,10,0,   1,0,3,0,0,2));
    tbl.push_back(V(0,1,0,0,3,11,0,   0,0,3,1,0,0));
    tbl.push_back(V(0,1,0,0,3,11,0,   0,0,3,1,0,0));
    tbl.push_back(V(0,0,1,3,0,12,0,   0,1,3,0,0,0));
    tbl.push_back(V(0,1,0,0,3,11,0,   0,0,3,1,0,0));
    tbl.push_back(V(0,1,0,0,3,11,1,   0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,3,11,0,   1,0,1,0,0,3));
    tbl.push_back(V(0,1,1,1,4,9,0,    0,0,1,0,1,0));
    tbl.push_back(V(0,1,0,0,4,9,0,    0,0,1,0,1,0));
    tbl.push_back(V(1,0,0,0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,8,20,0,   1,0,1,0,0,8));
    tbl.push_back(V(0,0,1,2,0,21,0,   0,1,1,0,1,0));
    tbl.push_back(V(0,0,0,0,0,0,1,    0,0,0,0,1,0));
    tbl.push_back(V(0,0,0,0,0,0,0,    0,0,0,0,1,0));
    tbl.push_back(V(1,0,0,0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(V(0,0,1,0,0,22,0,   0,1,0,0,1,0));
    tbl.push_back(V(0,0,0,0,0,0,1,    0,0,0,0,1,0));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Done timeout with a put held against the stall
    step(V(1,0,0,0,0,0,0,      0,0,0,0,0,0), 1'b1);
    step(V(0,1,0,0,'h11,30,0,  1,0,1,0,0,'h11), 1'b1);
    step(V(0,0,1,1,0,31,0,     0,1,1,0,0,0), 1'b1);
    for (int i = 0; i < DONE_TO; i++) begin
      step(V(0,1,0,0,'h55,32,0, 0,0, (i == DONE_TO-1) ? 0 : 1, 1,
             (i == DONE_TO-1) ? 1 : 0, 0), 1'b1);
    end
    step(V(0,1,0,0,'h55,32,0,  1,0,1,0,1,'h55), 1'b1);

    // Reset during the op_en pulse, then during a later BUSY cycle
    step(V(0,0,1,1,0,33,0,     0,1,1,0,1,0), 1'b1);
    step(V(1,0,0,0,0,0,0,      0,0,0,0,0,0), 1'b1);
    step(V(0,1,0,0,'h66,34,0,  1,0,1,0,0,'h66), 1'b1);
    step(V(0,0,1,1,0,35,0,     0,1,1,0,0,0), 1'b1);
    step(V(0,0,0,0,0,0,0,      0,0,1,0,0,0), 1'b1);
    step(V(1,0,0,0,0,0,0,      0,0,0,0,0,0), 1'b1);
    step(V(0,0,0,0,0,0,0,      0,0,0,0,0,0), 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      vec_t t;
      t = V(($urandom_range(0, 99) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            $urandom_range(0, 3),
            $urandom_range(0, 255),
            $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0) ? 1 : 0,
            0, 0, 0, 0, 0, 0);
      step(t, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
